// File: rtl/word_narrower_32to16.sv
// word_narrower_32to16
//   Splits a 32-bit word into 16-bit half-word beats on a valid/ready
//   stream, low half first. When COMPRESS_EN is set, a word that is the
//   sign extension of its low half goes out as a single beat. The
//   receiver rebuilds it with a 16->32 sign extender.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   in_word is valid
//   in_ready   out  1   block accepts in_word this cycle
//   in_word    in   32  word to narrow
//   out_valid  out  1   out_half is valid
//   out_ready  in   1   downstream accepts out_half this cycle
//   out_half   out  16  current half-word beat
//   out_first  out  1   beat carries bits[15:0]
//   out_last   out  1   final beat of the current word
//   out_fits   out  1   current word is sign-extendable from 16 bits
module word_narrower_32to16 #(
  parameter bit COMPRESS_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_half,
  output logic        out_first,
  output logic        out_last,
  output logic        out_fits
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

  state_t      state;
  logic [31:0] word_p0;
  logic        out_fire;
  logic        last_fire;
  logic        accept;

  // True when the upper half is nothing but copies of bit 15.
  function automatic logic sign_fits(input logic [31:0] w);
    return w[31:16] == {16{w[15]}};
  endfunction

  assign out_fire  = out_valid & out_ready;
  assign last_fire = out_fire & out_last;
  // A new word may enter in the same cycle the previous word's final
  // beat leaves, which gives one word per cycle for compressible data.
  assign in_ready  = !rst && ((state == IDLE) || last_fire);
  assign accept    = in_valid & in_ready;

  // Stage p0: captured word (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      word_p0 <= in_word;
    end
  end

  // Output beat register and state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_half  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      out_fits  <= 1'b0;
    end else if (accept) begin
      state     <= LOW;
      out_valid <= 1'b1;
      out_half  <= in_word[15:0];
      out_first <= 1'b1;
      out_fits  <= sign_fits(in_word);
      out_last  <= sign_fits(in_word) & COMPRESS_EN;
    end else if (out_fire && !out_last) begin
      state     <= HIGH;
      out_half  <= word_p0[31:16];
      out_first <= 1'b0;
      out_last  <= 1'b1;
    end else if (last_fire) begin
      // Final beat gone and nothing new: payload fields hold their values.
      state     <= IDLE;
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_word_narrower_32to16.sv
module tb_word_narrower_32to16;

  typedef struct {
    logic [15:0] half;
    bit          first;
    bit          last;
    bit          fits;
  } beat_t;

  typedef struct {
    int          sel;
    logic [31:0] word;
    int          beats;
    logic [15:0] h0;
    logic [15:0] h1;
    bit          fits;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [2];
  logic        ir   [2];
  logic [31:0] wd   [2];
  logic        ov   [2];
  logic        ord  [2];
  logic [15:0] oh   [2];
  logic        of   [2];
  logic        ol   [2];
  logic        ofit [2];

  int checks = 0;
  int errors = 0;

  beat_t q0[$];
  beat_t q1[$];
  bit    accd[2];

  always #5 clk = ~clk;

  // Instance 0 compresses, instance 1 always sends two beats.
  word_narrower_32to16 #(.COMPRESS_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_word(wd[0]),
    .out_valid(ov[0]), .out_ready(ord[0]), .out_half(oh[0]),
    .out_first(of[0]), .out_last(ol[0]), .out_fits(ofit[0])
  );

  word_narrower_32to16 #(.COMPRESS_EN(1'b0)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_word(wd[1]),
    .out_valid(ov[1]), .out_ready(ord[1]), .out_half(oh[1]),
    .out_first(of[1]), .out_last(ol[1]), .out_fits(ofit[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Reference: a word is a list of beats; it fits when its signed value
  // lies in the 16-bit signed range.
  task automatic push_word(input int k, input logic [31:0] w);
    beat_t b;
    bit fits;
    fits = ($signed(w) >= -32768) && ($signed(w) <= 32767);
    if (fits && k == 0) begin
      b.half = w[15:0]; b.first = 1; b.last = 1; b.fits = 1;
      q0.push_back(b);
    end else begin
      b.half = w[15:0]; b.first = 1; b.last = 0; b.fits = fits;
      if (k == 0) q0.push_back(b); else q1.push_back(b);
      b.half = w[31:16]; b.first = 0; b.last = 1;
      if (k == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic model_cycle(input int k);
    beat_t h;
    int n;
    bit eir, ev;
    n   = (k == 0) ? q0.size() : q1.size();
    eir = (n == 0) || (n == 1 && ord[k]);
    ev  = (n != 0);
    chk("in_ready", k, 32'(ir[k]), 32'(eir));
    chk("out_valid", k, 32'(ov[k]), 32'(ev));
    if (ev) begin
      h = (k == 0) ? q0[0] : q1[0];
      chk("out_half", k, 32'(oh[k]), 32'(h.half));
      chk("out_first", k, 32'(of[k]), 32'(h.first));
      chk("out_last", k, 32'(ol[k]), 32'(h.last));
      chk("out_fits", k, 32'(ofit[k]), 32'(h.fits));
      if (ord[k]) begin
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    accd[k] = iv[k] && eir;
    if (accd[k]) push_word(k, wd[k]);
  endtask

  // One clock cycle: drive the selected instance, idle the other, then
  // check both against the reference before the next rising edge.
  task automatic step(input int s, input bit v, input logic [31:0] w, input bit r, output bit acc);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; wd[k] = '0; ord[k] = 1'b1;
    end
    iv[s] = v; wd[s] = w; ord[s] = r;
    #1;
    model_cycle(0);
    model_cycle(1);
    acc = accd[s];
  endtask

  vec_t tbl[7];

  initial begin
    bit a, v, r, pend;
    logic [31:0] w;

    tbl[0] = '{0, 32'h0000_1234, 1, 16'h1234, 16'h0000, 1};
    tbl[1] = '{0, 32'hFFFF_8000, 1, 16'h8000, 16'hFFFF, 1};
    tbl[2] = '{0, 32'h0000_8000, 2, 16'h8000, 16'h0000, 0};
    tbl[3] = '{0, 32'h0000_7FFF, 1, 16'h7FFF, 16'h0000, 1};
    tbl[4] = '{0, 32'hFFFF_7FFF, 2, 16'h7FFF, 16'hFFFF, 0};
    tbl[5] = '{1, 32'h0000_1234, 2, 16'h1234, 16'h0000, 1};
    tbl[6] = '{1, 32'hFFFF_FFFF, 2, 16'hFFFF, 16'hFFFF, 1};

    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      iv[k] = 1'b0; wd[k] = '0; ord[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_out_valid", k, 32'(ov[k]), 32'd0);
      chk("rst_out_half", k, 32'(oh[k]), 32'd0);
      chk("rst_out_first", k, 32'(of[k]), 32'd0);
      chk("rst_out_last", k, 32'(ol[k]), 32'd0);
      chk("rst_out_fits", k, 32'(ofit[k]), 32'd0);
      chk("rst_in_ready", k, 32'(ir[k]), 32'd0);
    end
    rst = 1'b0;

    // Single-word table
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].sel, 1, tbl[i].word, 1, a);
      step(tbl[i].sel, 0, 32'h0, 1, a);
      chk("tbl_h0", i, 32'(oh[tbl[i].sel]), 32'(tbl[i].h0));
      chk("tbl_first0", i, 32'(of[tbl[i].sel]), 32'd1);
      chk("tbl_last0", i, 32'(ol[tbl[i].sel]), 32'(tbl[i].beats == 1));
      chk("tbl_fits", i, 32'(ofit[tbl[i].sel]), 32'(tbl[i].fits));
      if (tbl[i].beats == 2) begin
        step(tbl[i].sel, 0, 32'h0, 1, a);
        chk("tbl_h1", i, 32'(oh[tbl[i].sel]), 32'(tbl[i].h1));
        chk("tbl_first1", i, 32'(of[tbl[i].sel]), 32'd0);
        chk("tbl_last1", i, 32'(ol[tbl[i].sel]), 32'd1);
      end
      step(tbl[i].sel, 0, 32'h0, 1, a);
    end

    // Stall in LOW for five cycles
    step(0, 1, 32'h0001_8000, 1, a);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 32'h0, 0, a);
      chk("stall_half", c, 32'(oh[0]), 32'h8000);
      chk("stall_in_ready", c, 32'(ir[0]), 32'd0);
    end
    step(0, 0, 32'h0, 1, a);
    step(0, 0, 32'h0, 1, a);
    chk("release_half", 0, 32'(oh[0]), 32'h0001);
    chk("release_last", 0, 32'(ol[0]), 32'd1);

    // Back-to-back words
    step(0, 1, 32'h0000_0001, 1, a);
    step(0, 1, 32'hFFFF_FFFF, 1, a);
    chk("b2b_half0", 0, 32'(oh[0]), 32'h0001);
    chk("b2b_ready0", 0, 32'(ir[0]), 32'd1);
    step(0, 1, 32'h1234_5678, 1, a);
    chk("b2b_half1", 0, 32'(oh[0]), 32'hFFFF);
    chk("b2b_ready1", 0, 32'(ir[0]), 32'd1);
    step(0, 0, 32'h0, 1, a);
    chk("b2b_half2", 0, 32'(oh[0]), 32'h5678);
    step(0, 0, 32'h0, 1, a);
    chk("b2b_half3", 0, 32'(oh[0]), 32'h1234);
    chk("b2b_ready3", 0, 32'(ir[0]), 32'd1);
    step(0, 0, 32'h0, 1, a);

    // Reset while the high half is presented
    step(1, 1, 32'h0000_1234, 1, a);
    step(1, 0, 32'h0, 1, a);
    step(1, 0, 32'h0, 0, a);
    chk("pre_rst_half", 1, 32'(oh[1]), 32'h0000);
    chk("pre_rst_last", 1, 32'(ol[1]), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 1, 32'(ov[1]), 32'd0);
    chk("mid_rst_ready", 1, 32'(ir[1]), 32'd0);
    chk("mid_rst_last", 1, 32'(ol[1]), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    step(1, 1, 32'hABCD_0001, 1, a);
    step(1, 0, 32'h0, 1, a);
    chk("post_rst_half", 1, 32'(oh[1]), 32'h0001);
    chk("post_rst_first", 1, 32'(of[1]), 32'd1);
    step(1, 0, 32'h0, 1, a);
    step(1, 0, 32'h0, 1, a);

    // Random traffic against the reference
    for (int s = 0; s < 2; s++) begin
      pend = 0;
      v = 0;
      w = '0;
      for (int c = 0; c < 1500; c++) begin
        if (!pend) begin
          v = ($urandom_range(0, 3) != 0);
          w = $urandom;
          if ($urandom_range(0, 1) == 1) w = {{16{w[15]}}, w[15:0]};
        end
        r = ($urandom_range(0, 3) != 0);
        step(s, v, w, r, a);
        pend = v && !a;
      end
      repeat (3) step(s, 0, 32'h0, 1, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
